// File: rtl/mux41_scan_ctrl.sv
// mux41_scan_ctrl: steps a 4:1 mux select through channels 0..3, samples y after a settle time and reports a 4-bit result
module mux41_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode_cont,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t     state;
  logic [1:0] sel;
  logic [7:0] cnt;
  logic [3:0] shadow;
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $fatal(1, "SETTLE_CYCLES must be in 1..255");
  end
  assign {s1, s0} = sel;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= 2'd0;
      cnt    <= 8'd0;
      shadow <= 4'd0;
      sample <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel <= 2'd0;
          if (start) begin
            state  <= SETTLE;
            cnt    <= 8'd0;
            shadow <= 4'd0;
            busy   <= 1'b1;
          end
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'(SETTLE_CYCLES - 1)) state <= SAMPLE;
        end
        SAMPLE: begin
          shadow[sel] <= y;
          if (sel != 2'd3) begin
            sel   <= sel + 2'd1;
            cnt   <= 8'd0;
            state <= SETTLE;
          end else begin
            sample <= {y, shadow[2:0]};
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          sel  <= 2'd0;
          if (mode_cont) begin
            cnt    <= 8'd0;
            shadow <= 4'd0;
            state  <= SETTLE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// tb_mux41_scan_ctrl: randomized scoreboard bench for mux41_scan_ctrl at two settle lengths
module tb_mux41_scan_ctrl;
  typedef struct {
    int         e;
    logic [3:0] v;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst, start, mode_cont;
  logic [3:0] ins;
  int         n_chk = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int g, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t got=%0d expected=%0d", nm, g, $time, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int S = (g == 0) ? 2 : 1;
    logic       s1, s0, busy, done, y;
    logic [3:0] sample;
    logic [3:0] hist [0:4095];
    exp_t       q[$];
    assign y = ins[{s1, s0}];
    mux41_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .start(start), .mode_cont(mode_cont), .y(y),
      .s1(s1), .s0(s0), .busy(busy), .done(done), .sample(sample)
    );
    initial begin
      int         e, e0, d, ch;
      bit         active;
      logic [3:0] exp_sample, v;
      exp_t       x;
      e = 1;
      e0 = 0;
      active = 0;
      exp_sample = 4'd0;
      forever begin
        @(negedge clk);
        d = e - e0;
        ch = active ? ((d / (S + 1) > 3) ? 3 : d / (S + 1)) : 0;
        chk("busy", g, int'(busy), int'(active));
        chk("select", g, int'({s1, s0}), ch);
        chk("done", g, int'(done), int'(active && d == 4 * (S + 1)));
        chk("sample_hold", g, int'(sample), int'(exp_sample));
        if (done) begin
          chk("sb_pending", g, int'(q.size() != 0), 1);
          if (q.size() != 0) begin
            x = q.pop_front();
            chk("sb_done_edge", g, e, x.e);
            chk("sb_result", g, int'(sample), int'(x.v));
          end
        end
        hist[e] = ins;
        e++;
        if (rst) begin
          active = 0;
          exp_sample = 4'd0;
          q.delete();
        end else if (!active) begin
          if (start) begin
            active = 1;
            e0 = e;
          end
        end else if (e - e0 == 4 * (S + 1)) begin
          for (int k = 0; k < 4; k++) v[k] = hist[e0 + k * (S + 1) + S][k];
          exp_sample = v;
          q.push_back('{e, v});
        end else if (e - e0 == 4 * (S + 1) + 1) begin
          if (mode_cont) e0 = e;
          else active = 0;
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    start = 1'b1;
    mode_cont = 1'b0;
    ins = 4'b0000;
    step(3);
    rst = 1'b0;
    start = 1'b0;
    step(3);
    ins = 4'b0101;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(20);
    ins = 4'b0011;
    mode_cont = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(30);
    ins = 4'b0110;
    step(30);
    mode_cont = 1'b0;
    step(20);
    ins = 4'b1001;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(20);
    ins = 4'b0101;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(20);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(6);
    for (int i = 0; i < 500; i++) begin
      ins = 4'($urandom);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) mode_cont = ~mode_cont;
      rst = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 1'b0;
    start = 1'b0;
    mode_cont = 1'b0;
    step(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux41_scan_ctrl.md
Name: mux41_scan_ctrl

Overview:
Upstream sequencer for the 4:1 mux (mux41). It drives the mux select lines s1/s0 through channels 0..3 in order. For each channel it waits a programmable settle time, then samples the mux output y. The four samples are assembled into one 4-bit result word, with a done pulse; single-shot or continuous scan.

Parameters:
SETTLE_CYCLES, 2, cycles select is held stable before y is sampled; legal range 1..255 (0 is illegal; flag in sim with a fatal check)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a scan; sampled only in IDLE
mode_cont  input  1  1 = rescan automatically after each completed scan; sampled only in DONE
y  input  1  output of the 4:1 mux being scanned
s1  output  1  mux select MSB, registered
s0  output  1  mux select LSB, registered
busy  output  1  high whenever state != IDLE
done  output  1  high for exactly one cycle per completed scan (state == DONE)
sample  output  4  last completed scan result; bit k = y observed with {s1,s0} = k

Behaviour:
- States: IDLE, SETTLE, SAMPLE, DONE. Internal regs: 2-bit sel (drives {s1,s0}), 8-bit settle counter cnt, 4-bit shadow.
- Reset (rst=1 at a rising edge, any state):
  - state=IDLE, sel=0 (s1=s0=0), cnt=0, shadow=0, sample=0, busy=0, done=0.
  - Reset mid-scan aborts the scan; no partial result is written to sample.
- IDLE: {s1,s0}=00.
  - start=1 -> SETTLE, sel=0, cnt=0, shadow=0.
  - start=0 -> stay in IDLE.
- SETTLE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1 -> SAMPLE. SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE: lasts one cycle; shadow[sel] <= y at the edge ending the cycle.
  - sel<3: sel <= sel+1, cnt <= 0, -> SETTLE.
  - sel==3: sample <= shadow with bit 3 replaced by the current y (all 4 bits committed on the same edge), -> DONE.
- DONE: lasts one cycle, done=1.
  - mode_cont=1: -> SETTLE, sel=0, cnt=0, shadow=0.
  - mode_cont=0: -> IDLE, sel=0.
- Select timing:
  - {s1,s0} changes only on the edges leaving SAMPLE or DONE.
  - It is constant for the whole SETTLE+SAMPLE window of a channel, which is SETTLE_CYCLES+1 cycles.
- Latency: with start seen at edge E0, channel k occupies the cycles after edges E0+k*(S+1) .. E0+(k+1)*(S+1)-1, where S=SETTLE_CYCLES.
  - done is high in the cycle after edge E0+4*(S+1).
  - With S=2: done is high 12 edges after E0.
- Continuous mode: one scan every 4*(S+1)+1 cycles. busy stays high and done pulses once per scan.
- sample holds its value between scans. It changes only on the edge entering DONE.
- start asserted while busy: ignored, no restart and no queuing. start held high in IDLE after DONE starts a new scan on the next edge.
- mode_cont changes mid-scan: no effect until DONE is reached.
- y is assumed synchronous to clk (the mux is combinational from the registered selects); no synchronizer inside.

Test Plan:
- Reset: assert rst 3 cycles with start=1 -> s1=s0=0, busy=0, done=0, sample=4'b0000 throughout and on the first cycle after release.
- Single scan: mux inputs i0=1,i1=0,i2=1,i3=0, S=2, one-cycle start pulse -> selects step 00,01,10,11 with 3 cycles each; done pulses once 12 edges after the start edge; sample=4'b0101; then IDLE, busy=0.
- Continuous: mode_cont=1, inputs 1,1,0,0 -> done every 13 cycles, sample=4'b0011. Change inputs to 0,1,1,0 mid-run -> the next full scan gives 4'b0110. Drop mode_cont -> returns to IDLE after the current DONE.
- Start while busy: pulse start 5 cycles into a scan -> done timing unchanged from the original start; only one done pulse.
- Reset mid-scan: rst during channel 2 SETTLE with prior sample=4'b0101 -> next cycle sample=0, state IDLE, {s1,s0}=00, no done pulse.
- Settle boundary: SETTLE_CYCLES=1; toggle y on the cycle selects change -> the value present in the SAMPLE cycle is captured; the total scan is 8 cycles to done.
